// File: rtl/window_gen_if.sv
// Column-in / window-out handshake bundle for window_gen.
interface window_gen_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LENGTH  = 32,
  parameter int KERNEL_LENGTH = 3
);
  localparam int CW = $clog2(BURST_LENGTH);

  logic in_valid;
  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] in_data;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0]
        [DATA_WIDTH-1:0] out_win;
  logic [CW-1:0] out_col;
  logic out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win,
    input  out_col, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win,
    output out_col, out_last
  );
endinterface

// File: rtl/window_gen.sv
// Sliding KxK window generator over column stream, one-deep output.
// Optional WINDOW_GEN_STRIDE2_EN: horizontal stride of two.
module window_gen #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LENGTH  = 32,
  parameter int KERNEL_LENGTH = 3
) (
  input logic clk,
  input logic rst,
  window_gen_if.slave bus
);
  localparam int CW = $clog2(BURST_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(BURST_LENGTH - 1);
  localparam logic [CW-1:0] FEND = CW'(KERNEL_LENGTH - 2);

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] col_cnt, col_nx;
  logic [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0]
        [DATA_WIDTH-1:0] win;
  logic out_valid_q;
  logic out_last_q;
  logic [CW-1:0] out_col_q;
  logic in_ready;
  logic accept;
  logic eligible;
  logic stride_ok;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

`ifdef WINDOW_GEN_STRIDE2_EN
  // Column parity matching KERNEL_LENGTH-1 keeps the offset even
  localparam logic PAR = ((KERNEL_LENGTH - 1) % 2) != 0;
  assign stride_ok = (col_cnt[0] == PAR);
`else
  assign stride_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    col_nx   = col_cnt;
    eligible = 1'b0;
    if (accept)
      col_nx = (col_cnt == LAST) ? '0 : col_cnt + 1'b1;
    unique case (state)
      FILL: begin
        if (accept && col_cnt == FEND)
          state_nx = RUN;
      end
      RUN: begin
        eligible = accept && stride_ok;
        if (accept && col_cnt == LAST)
          state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      col_cnt     <= '0;
      win         <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      col_cnt <= col_nx;
      if (accept) begin
        for (int r = 0; r < KERNEL_LENGTH; r++) begin
          for (int c = 0; c < KERNEL_LENGTH - 1; c++)
            win[r][c] <= win[r][c+1];
          win[r][KERNEL_LENGTH-1] <= bus.in_data[r];
        end
      end
      if (eligible) begin
        out_valid_q <= 1'b1;
        out_col_q   <= col_cnt;
        out_last_q  <= (col_cnt == LAST);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_win   = win;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen: vector table,
// directed corner sequences, random traffic vs. scoreboard.
module tb_window_gen;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int K  = 3;
  localparam int CW = $clog2(BL);

`ifdef WINDOW_GEN_STRIDE2_EN
  localparam bit STRIDE = 1'b1;
`else
  localparam bit STRIDE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  window_gen_if #(
    .DATA_WIDTH(DW),
    .BURST_LENGTH(BL),
    .KERNEL_LENGTH(K)
  ) bus ();

  window_gen #(
    .DATA_WIDTH(DW),
    .BURST_LENGTH(BL),
    .KERNEL_LENGTH(K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef logic [K-1:0][DW-1:0] col_t;
  typedef logic [K-1:0][K-1:0][DW-1:0] win_t;

  typedef struct {
    win_t win;
    int   col;
    logic last;
  } exp_t;

  typedef struct {
    logic v;
    int   c;
    logic rdy;
    logic ev;
    int   ecol;
    logic elast;
    int   ebase;
  } vec_t;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic bit elig(int c);
    if (c < K - 1) return 1'b0;
    if (STRIDE) return ((c - (K - 1)) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic col_t mk(int c);
    col_t d;
    for (int r = 0; r < K; r++) d[r] = DW'(r * 16 + c);
    return d;
  endfunction

  // Reference model: per-row column store + queue of
  // windows owed to the downstream side.
  exp_t q[$];
  col_t cols[BL];
  int   mcol = 0;
  exp_t e;
  exp_t ne;
  logic m_ready;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcol = 0;
    end else begin
      m_ready = (q.size() == 0) || bus.out_ready;
      chk("in_ready", bus.in_ready, m_ready);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (bus.out_valid && bus.out_ready
          && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_col", bus.out_col, e.col);
        chk("sb_last", bus.out_last, e.last);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            chk("sb_win", bus.out_win[r][c], e.win[r][c]);
      end
      if (bus.in_valid && m_ready) begin
        cols[mcol] = bus.in_data;
        if (elig(mcol)) begin
          for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
              ne.win[r][c] = cols[mcol - (K - 1) + c][r];
          ne.col  = mcol;
          ne.last = (mcol == BL - 1);
          q.push_back(ne);
        end
        mcol = (mcol + 1) % BL;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int c,
                       input logic rdy);
    bus.in_valid  = v;
    bus.out_ready = rdy;
    if (v) begin
      bus.in_data = mk(c);
    end else begin
      for (int r = 0; r < K; r++)
        bus.in_data[r] = $urandom();
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  int   lastc;
  logic lastl;
  int   hold_col;
  logic b;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_data   = '0;

    do_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_col", bus.out_col, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk("rst_win", bus.out_win[r][c], 0);

    lastc = 0;
    lastl = 1'b0;
    for (int i = 0; i < BL; i++) begin
      b = elig(i);
      if (b) begin
        lastc = i;
        lastl = (i == BL - 1);
      end
      tbl[i] = '{1'b1, i, 1'b1, b, lastc, lastl, i - 2};
    end
    tbl[8] = '{1'b0, 0, 1'b1, 1'b0, lastc, lastl, 0};
    tbl[9] = '{1'b0, 0, 1'b1, 1'b0, lastc, lastl, 0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].rdy);
      step();
      chk("tbl_valid", bus.out_valid, tbl[i].ev);
      chk("tbl_col", bus.out_col, tbl[i].ecol);
      chk("tbl_last", bus.out_last, tbl[i].elast);
      if (tbl[i].ev)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            chk("tbl_win", bus.out_win[r][c],
                r * 16 + tbl[i].ebase + c);
    end

    // Downstream stall while a window is pending
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, c, 1'b1);
      step();
    end
    hold_col = 2;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3, 1'b0);
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      step();
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_col", bus.out_col, hold_col);
      chk("stall_win00", bus.out_win[0][0], 0);
      chk("stall_win22", bus.out_win[2][2], 34);
    end
    for (int c = 3; c < BL; c++) begin
      drive(1'b1, c, 1'b1);
      step();
      if (c == 3)
        chk("resume_col", bus.out_col, STRIDE ? 2 : 3);
    end
    drive(1'b0, 0, 1'b1);
    step();

    // Reset mid-row discards pending window and partial row
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, c, 1'b1);
      step();
    end
    chk("pre_rst_valid", bus.out_valid, 1);
    drive(1'b1, 9, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_col", bus.out_col, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, c, 1'b1);
      step();
      chk("post_rst_valid", bus.out_valid, c == 2);
    end
    chk("post_rst_col", bus.out_col, 2);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        chk("post_rst_win", bus.out_win[r][c], r * 16 + c);
    drive(1'b0, 0, 1'b1);
    step();

    // Continuous multi-row stream, then random traffic
    do_reset();
    for (int i = 0; i < 3 * BL; i++) begin
      drive(1'b1, 0, 1'b1);
      for (int r = 0; r < K; r++)
        bus.in_data[r] = $urandom();
      step();
    end
    for (int i = 0; i < 800; i++) begin
      drive(1'b0, 0, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        for (int r = 0; r < K; r++)
          bus.in_data[r] = $urandom();
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 0, 1'b1);
      step();
    end
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of one pixel.
REQ-002 SHALL have parameter BURST_LENGTH, default 32, pixels per image row (columns per row); minimum KERNEL_LENGTH.
REQ-003 SHALL have parameter KERNEL_LENGTH, default 3, window is KERNEL_LENGTH x KERNEL_LENGTH.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream column-buffer valid; one vertical column present.
REQ-007 SHALL have port in_data  input  [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]  column, index r = kernel row r.
REQ-008 SHALL have port in_ready  output  1  column accepted this cycle when in_valid && in_ready; drives upstream ren.
REQ-009 SHALL have port out_valid  output  1  window valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts window when out_valid && out_ready.
REQ-011 SHALL have port out_win  output  [KERNEL_LENGTH-1:0][KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]  window [r][c], c=KERNEL_LENGTH-1 newest column.
REQ-012 SHALL have port out_col  output  [$clog2(BURST_LENGTH)-1:0]  row-column index of newest column in out_win.
REQ-013 SHALL have port out_last  output  1  out_win is final window of its row.

Function
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational; one-deep output register, no bubble under continuous flow).
REQ-015 On accept, window SHALL shift: win[r][c] <= win[r][c+1] for c<KERNEL_LENGTH-1, win[r][KERNEL_LENGTH-1] <= in_data[r].
REQ-016 Column counter col_cnt SHALL increment on each accept and wrap BURST_LENGTH-1 -> 0; no change without accept.
REQ-017 State SHALL be FILL when col_cnt < KERNEL_LENGTH-1, RUN otherwise; FILL->RUN on accept at col_cnt=KERNEL_LENGTH-2; RUN->FILL on accept at col_cnt=BURST_LENGTH-1.
REQ-018 An accept with pre-increment col_cnt >= KERNEL_LENGTH-1 (eligible) SHALL set out_valid=1 next cycle, out_col=col_cnt, out_last=(col_cnt==BURST_LENGTH-1); latency 1 cycle.
REQ-019 Windows straddling two rows SHALL never be emitted; first KERNEL_LENGTH-1 accepts of every row produce no window.
REQ-020 out_valid && !out_ready SHALL hold out_win, out_col, out_last, out_valid stable; no accept occurs (in_ready=0).
REQ-021 out_valid SHALL clear on out_ready when the same cycle has no eligible accept; fire plus eligible accept SHALL reload with out_valid staying 1.
REQ-022 out_win SHALL only update on accept; non-eligible accepts update internal window while out_valid=0.
REQ-023 in_data SHALL be ignored when in_valid=0.

Reset
REQ-024 rst SHALL clear out_valid, out_last, out_col, col_cnt, and all window registers to 0, state FILL; in_ready=1 after reset.
REQ-025 rst mid-row SHALL discard any pending window and partial row; next accepted column is column 0.
REQ-026 rst SHALL take priority over accept and out_ready in the same cycle.

Configuration
REQ-027 Macro WINDOW_GEN_STRIDE2_EN defined: eligibility additionally requires (col_cnt-(KERNEL_LENGTH-1)) even, giving horizontal stride 2; undefined: stride 1, every eligible column emits.
REQ-028 Stride option SHALL not alter in_ready, col_cnt, or row-boundary behaviour; out_last asserts only if column BURST_LENGTH-1 is eligible.

Verification (KERNEL_LENGTH=3, BURST_LENGTH=8, DATA_WIDTH=32)
REQ-029 Reset, then 8 columns {c,c,c}+r*16 (c=0..7) with out_ready=1 -> 6 windows, first at cycle after column 2 with out_win[r]={r*16+0,+1,+2}, out_col=2; last out_col=7, out_last=1.
REQ-030 Two consecutive rows back-to-back -> no window with out_col<2 in row 2; first row-2 window contains only row-2 columns.
REQ-031 out_ready=0 for 4 cycles while out_valid=1 -> in_ready=0, out_win/out_col stable, no column lost; resumes in order.
REQ-032 rst asserted after column 4 -> out_valid=0 next cycle; following columns 0..2 produce first window at out_col=2.
REQ-033 WINDOW_GEN_STRIDE2_EN defined, one 8-column row -> windows at out_col=2,4,6 only, out_last never 1.
REQ-034 in_valid toggled randomly with out_ready=1 -> window sequence identical to continuous case.
